// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared widths, beat count and state/op encodings for the
//                memory stage and its bitmap beat buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int BMP_BITS  = 1536;
    localparam int WORD_BITS = 16;
    localparam int BMP_BEATS = 96;
    localparam int BEAT_W    = 7;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BMP_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD  = 2'd1,
        BURST = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LD   = 3'd1,
        OP_ST   = 3'd2,
        OP_LDB  = 3'd3,
        OP_STB  = 3'd4
    } op_e;

endpackage
`default_nettype wire

// File: rtl/bmp_beat_buf.sv
`default_nettype none
// ============================================================================
//  Module      : bmp_beat_buf
//  Description : 96 x 16 beat buffer: parallel bitmap load, indexed beat
//                write, indexed beat read and flat full-bitmap read.
//  Revision    : 1.0 - initial release
// ============================================================================
module bmp_beat_buf
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 load_en,
    input  logic [BMP_BITS-1:0]  load_data,
    input  logic                 wr_en,
    input  logic [BEAT_W-1:0]    wr_idx,
    input  logic [WORD_BITS-1:0] wr_data,
    input  logic [BEAT_W-1:0]    rd_idx,
    output logic [WORD_BITS-1:0] rd_data,
    output logic [BMP_BITS-1:0]  all_data
);

    logic [WORD_BITS-1:0] beats_q [BMP_BEATS];
    logic [WORD_BITS-1:0] beats_d [BMP_BEATS];

    always_comb begin
        beats_d = beats_q;
        if (load_en) begin
            for (int i = 0; i < BMP_BEATS; i++) begin
                beats_d[i] = load_data[i*WORD_BITS +: WORD_BITS];
            end
        end else if (wr_en && (wr_idx < BEAT_W'(BMP_BEATS))) begin
            beats_d[wr_idx] = wr_data;
        end
    end

    // Pure datapath storage: contents are only meaningful after a load or burst.
    always_ff @(posedge clk) begin
        beats_q <= beats_d;
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < BEAT_W'(BMP_BEATS)) begin
            rd_data = beats_q[rd_idx];
        end
    end

    generate
        for (genvar g = 0; g < BMP_BEATS; g++) begin : g_flat
            assign all_data[g*WORD_BITS +: WORD_BITS] = beats_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage: scalar load/store, 96-beat bitmap
//                load/store bursts and registered writeback with stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [15:0]          rd_data,
    input  logic [1535:0]        bd_data,
    input  logic [15:0]          st_data,
    input  logic [3:0]           rd_addr,
    input  logic [1:0]           bd_addr,
    input  logic                 ld,
    input  logic                 st,
    input  logic                 ldb,
    input  logic                 stb,
    input  logic                 wr_rd,
    input  logic                 wr_bd,
    output logic [15:0]          mem_addr,
    output logic [15:0]          mem_wdata,
    output logic                 mem_re,
    output logic                 mem_we,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic [15:0]          wb_rd_data,
    output logic [1535:0]        wb_bd_data,
    output logic [3:0]           wb_rd_addr,
    output logic [1:0]           wb_bd_addr,
    output logic                 wb_rd_we,
    output logic                 wb_bd_we,
    output logic                 stall
);

    state_e                state_q,      state_d;
    op_e                   op_q,         op_d;
    logic [BEAT_W-1:0]     beat_q,       beat_d;
    logic [15:0]           base_q,       base_d;
    logic [3:0]            dst_rd_q,     dst_rd_d;
    logic [1:0]            dst_bd_q,     dst_bd_d;
    logic [15:0]           mem_addr_q,   mem_addr_d;
    logic [15:0]           mem_wdata_q,  mem_wdata_d;
    logic                  mem_re_q,     mem_re_d;
    logic                  mem_we_q,     mem_we_d;
    logic [15:0]           wb_rd_data_q, wb_rd_data_d;
    logic [BMP_BITS-1:0]   wb_bd_data_q, wb_bd_data_d;
    logic [3:0]            wb_rd_addr_q, wb_rd_addr_d;
    logic [1:0]            wb_bd_addr_q, wb_bd_addr_d;
    logic                  wb_rd_we_q,   wb_rd_we_d;
    logic                  wb_bd_we_q,   wb_bd_we_d;

    logic                  w_buf_load;
    logic                  w_buf_wr;
    logic [BEAT_W-1:0]     w_next_beat;
    logic [WORD_BITS-1:0]  w_buf_rd;
    logic [BMP_BITS-1:0]   w_buf_all;

    assign w_next_beat = beat_q + BEAT_W'(1);

    // Store bursts preload the buffer and stream beats out of it; load bursts
    // fill it beat by beat.
    bmp_beat_buf u_buf (
        .clk       (clk),
        .load_en   (w_buf_load),
        .load_data (bd_data),
        .wr_en     (w_buf_wr),
        .wr_idx    (beat_q),
        .wr_data   (mem_rdata),
        .rd_idx    (w_next_beat),
        .rd_data   (w_buf_rd),
        .all_data  (w_buf_all)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        beat_d       = beat_q;
        base_d       = base_q;
        dst_rd_d     = dst_rd_q;
        dst_bd_d     = dst_bd_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        wb_rd_data_d = wb_rd_data_q;
        wb_bd_data_d = wb_bd_data_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_bd_addr_d = wb_bd_addr_q;
        wb_rd_we_d   = 1'b0;
        wb_bd_we_d   = 1'b0;
        w_buf_load   = 1'b0;
        w_buf_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    base_d   = rd_data;
                    dst_rd_d = rd_addr;
                    dst_bd_d = bd_addr;
                    beat_d   = '0;
                    if (ldb) begin
                        op_d       = OP_LDB;
                        state_d    = BURST;
                        mem_addr_d = rd_data;
                        mem_re_d   = 1'b1;
                    end else if (stb) begin
                        op_d        = OP_STB;
                        state_d     = BURST;
                        mem_addr_d  = rd_data;
                        mem_wdata_d = bd_data[WORD_BITS-1:0];
                        mem_we_d    = 1'b1;
                        w_buf_load  = 1'b1;
                    end else if (ld) begin
                        op_d       = OP_LD;
                        state_d    = WORD;
                        mem_addr_d = rd_data;
                        mem_re_d   = 1'b1;
                    end else if (st) begin
                        op_d        = OP_ST;
                        state_d     = WORD;
                        mem_addr_d  = rd_data;
                        mem_wdata_d = st_data;
                        mem_we_d    = 1'b1;
                    end else begin
                        op_d = OP_NONE;
                        if (wr_rd) begin
                            wb_rd_data_d = rd_data;
                            wb_rd_addr_d = rd_addr;
                            wb_rd_we_d   = 1'b1;
                        end
                        if (wr_bd) begin
                            wb_bd_data_d = bd_data;
                            wb_bd_addr_d = bd_addr;
                            wb_bd_we_d   = 1'b1;
                        end
                    end
                end
            end

            WORD: begin
                if (mem_ready) begin
                    state_d  = IDLE;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (op_q == OP_LD) begin
                        wb_rd_data_d = mem_rdata;
                        wb_rd_addr_d = dst_rd_q;
                        wb_rd_we_d   = 1'b1;
                    end
                end
            end

            BURST: begin
                if (mem_ready) begin
                    w_buf_wr = (op_q == OP_LDB);
                    if (beat_q == LAST_BEAT) begin
                        state_d  = IDLE;
                        beat_d   = '0;
                        mem_re_d = 1'b0;
                        mem_we_d = 1'b0;
                        if (op_q == OP_LDB) begin
                            // Final beat lands in the buffer on this same edge,
                            // so splice it into the writeback copy directly.
                            wb_bd_data_d = w_buf_all;
                            wb_bd_data_d[BMP_BITS-WORD_BITS +: WORD_BITS] = mem_rdata;
                            wb_bd_addr_d = dst_bd_q;
                            wb_bd_we_d   = 1'b1;
                        end
                    end else begin
                        beat_d     = w_next_beat;
                        mem_addr_d = base_q + {{(16-BEAT_W){1'b0}}, w_next_beat};
                        if (op_q == OP_STB) begin
                            mem_wdata_d = w_buf_rd;
                        end
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_NONE;
            beat_q       <= '0;
            base_q       <= '0;
            dst_rd_q     <= '0;
            dst_bd_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            wb_rd_data_q <= '0;
            wb_bd_data_q <= '0;
            wb_rd_addr_q <= '0;
            wb_bd_addr_q <= '0;
            wb_rd_we_q   <= 1'b0;
            wb_bd_we_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            dst_rd_q     <= dst_rd_d;
            dst_bd_q     <= dst_bd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            wb_rd_data_q <= wb_rd_data_d;
            wb_bd_data_q <= wb_bd_data_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_bd_addr_q <= wb_bd_addr_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_bd_we_q   <= wb_bd_we_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign wb_rd_data = wb_rd_data_q;
    assign wb_bd_data = wb_bd_data_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_bd_addr = wb_bd_addr_q;
    assign wb_rd_we   = wb_rd_we_q;
    assign wb_bd_we   = wb_bd_we_q;
    assign stall      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [15:0]   rd_data;
    logic [1535:0] bd_data;
    logic [15:0]   st_data;
    logic [3:0]    rd_addr;
    logic [1:0]    bd_addr;
    logic          ld, st, ldb, stb, wr_rd, wr_bd;
    logic [15:0]   mem_addr, mem_wdata, mem_rdata;
    logic          mem_re, mem_we, mem_ready;
    logic [15:0]   wb_rd_data;
    logic [1535:0] wb_bd_data;
    logic [3:0]    wb_rd_addr;
    logic [1:0]    wb_bd_addr;
    logic          wb_rd_we, wb_bd_we, stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rd_data(rd_data),
        .bd_data(bd_data), .st_data(st_data), .rd_addr(rd_addr), .bd_addr(bd_addr),
        .ld(ld), .st(st), .ldb(ldb), .stb(stb), .wr_rd(wr_rd), .wr_bd(wr_bd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_rd_data(wb_rd_data), .wb_bd_data(wb_bd_data), .wb_rd_addr(wb_rd_addr),
        .wb_bd_addr(wb_bd_addr), .wb_rd_we(wb_rd_we), .wb_bd_we(wb_bd_we), .stall(stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; rd_data = '0; bd_data = '0; st_data = '0;
        rd_addr = '0; bd_addr = '0;
        ld = 0; st = 0; ldb = 0; stb = 0; wr_rd = 0; wr_bd = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        mem_ready = 0; mem_rdata = '0;
        rst_n = 0;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_re_we got=%b exp=00", {mem_re, mem_we}); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem got addr=%h wdata=%h exp=0", mem_addr, mem_wdata); end
        checks++; if ({wb_rd_we, wb_bd_we} !== 2'b00) begin errors++; $display("FAIL reset_wb_we got=%b exp=00", {wb_rd_we, wb_bd_we}); end
        checks++; if (wb_rd_data !== 16'h0 || wb_bd_data !== '0 || wb_rd_addr !== 4'h0 || wb_bd_addr !== 2'h0) begin
            errors++; $display("FAIL reset_wb_data got rd=%h rda=%h bda=%h exp=0", wb_rd_data, wb_rd_addr, wb_bd_addr);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_passthrough();
        clear_inputs();
        in_valid = 1; wr_rd = 1; rd_data = 16'h1234; rd_addr = 4'd5;
        tick();
        clear_inputs();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got=%b exp=0", stall); end
        checks++; if (wb_rd_we !== 1'b1 || wb_rd_data !== 16'h1234 || wb_rd_addr !== 4'd5) begin
            errors++; $display("FAIL pass_wb got we=%b data=%h addr=%0d exp we=1 data=1234 addr=5", wb_rd_we, wb_rd_data, wb_rd_addr);
        end
        checks++; if (wb_bd_we !== 1'b0) begin errors++; $display("FAIL pass_bd_we got=%b exp=0", wb_bd_we); end
        tick();
        checks++; if (wb_rd_we !== 1'b0 || wb_rd_data !== 16'h1234) begin
            errors++; $display("FAIL pass_pulse_end got we=%b data=%h exp we=0 data=1234", wb_rd_we, wb_rd_data);
        end
    endtask

    task automatic test_load_wait();
        int stalls = 0;
        clear_inputs();
        in_valid = 1; ld = 1; rd_data = 16'h0040; rd_addr = 4'd7;
        mem_ready = 0;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            if (stall === 1'b1) stalls++;
            checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040) begin
                errors++; $display("FAIL ld_req cyc=%0d got re=%b we=%b addr=%h exp re=1 we=0 addr=0040", i, mem_re, mem_we, mem_addr);
            end
            mem_ready = (i == 3);
            mem_rdata = (i == 3) ? 16'hBEEF : 16'h0000;
            tick();
        end
        mem_ready = 0;
        checks++; if (stalls != 4) begin errors++; $display("FAIL ld_stall_cycles got=%0d exp=4", stalls); end
        checks++; if (stall !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL ld_done got stall=%b re=%b exp 0 0", stall, mem_re); end
        checks++; if (wb_rd_we !== 1'b1 || wb_rd_data !== 16'hBEEF || wb_rd_addr !== 4'd7) begin
            errors++; $display("FAIL ld_wb got we=%b data=%h addr=%0d exp we=1 data=beef addr=7", wb_rd_we, wb_rd_data, wb_rd_addr);
        end
        tick();
        checks++; if (wb_rd_we !== 1'b0) begin errors++; $display("FAIL ld_pulse_end got=%b exp=0", wb_rd_we); end
    endtask

    task automatic test_store_burst();
        int n = 0;
        int wb_seen = 0;
        clear_inputs();
        for (int k = 0; k < 96; k++) bd_data[16*k +: 16] = 16'(k);
        in_valid = 1; stb = 1; rd_data = 16'hFFF0; bd_addr = 2'd1;
        mem_ready = 1;
        tick();
        clear_inputs();
        for (int cyc = 0; cyc < 200 && stall === 1'b1; cyc++) begin
            logic [15:0] exp_addr;
            exp_addr = 16'hFFF0 + 16'(n);
            checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== exp_addr || mem_wdata !== 16'(n)) begin
                errors++; $display("FAIL stb_beat k=%0d got we=%b re=%b addr=%h data=%h exp we=1 re=0 addr=%h data=%h",
                                   n, mem_we, mem_re, mem_addr, mem_wdata, exp_addr, 16'(n));
            end
            if (wb_bd_we === 1'b1 || wb_rd_we === 1'b1) wb_seen++;
            n++;
            tick();
        end
        if (wb_bd_we === 1'b1 || wb_rd_we === 1'b1) wb_seen++;
        mem_ready = 0;
        checks++; if (n != 96) begin errors++; $display("FAIL stb_beats got=%0d exp=96", n); end
        checks++; if (wb_seen != 0) begin errors++; $display("FAIL stb_no_wb got=%0d exp=0", wb_seen); end
        checks++; if (mem_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL stb_done got we=%b stall=%b exp 0 0", mem_we, stall); end
    endtask

    task automatic test_load_burst();
        int n = 0;
        int cyc = 0;
        int bad = 0;
        clear_inputs();
        in_valid = 1; ldb = 1; rd_data = 16'h0100; bd_addr = 2'd2;
        mem_ready = 0;
        tick();
        clear_inputs();
        while (stall === 1'b1 && cyc < 1000) begin
            if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0100 + 16'(n)) bad++;
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = 16'hA000 + 16'(n);
            cyc++;
            tick();
            if (mem_ready) n++;
        end
        mem_ready = 0;
        checks++; if (cyc >= 1000) begin errors++; $display("FAIL ldb_timeout got cycles=%0d exp <1000", cyc); end
        checks++; if (bad != 0) begin errors++; $display("FAIL ldb_requests got bad=%0d exp=0", bad); end
        checks++; if (n != 96) begin errors++; $display("FAIL ldb_beats got=%0d exp=96", n); end
        checks++; if (wb_bd_we !== 1'b1 || wb_bd_addr !== 2'd2) begin
            errors++; $display("FAIL ldb_wb got we=%b addr=%0d exp we=1 addr=2", wb_bd_we, wb_bd_addr);
        end
        for (int k = 0; k < 96; k++) begin
            checks++; if (wb_bd_data[16*k +: 16] !== 16'hA000 + 16'(k)) begin
                errors++; $display("FAIL ldb_slice k=%0d got=%h exp=%h", k, wb_bd_data[16*k +: 16], 16'hA000 + 16'(k));
            end
        end
        tick();
        checks++; if (wb_bd_we !== 1'b0) begin errors++; $display("FAIL ldb_pulse_end got=%b exp=0", wb_bd_we); end
    endtask

    task automatic test_priority();
        int we_seen = 0;
        int cyc = 0;
        clear_inputs();
        in_valid = 1; ld = 1; st = 1; rd_data = 16'h0200; st_data = 16'h5555; rd_addr = 4'd3;
        mem_ready = 1; mem_rdata = 16'h1111;
        tick();
        clear_inputs();
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_ld got re=%b we=%b exp re=1 we=0", mem_re, mem_we); end
        tick();
        checks++; if (wb_rd_we !== 1'b1 || wb_rd_data !== 16'h1111 || stall !== 1'b0) begin
            errors++; $display("FAIL prio_ld_wb got we=%b data=%h stall=%b exp we=1 data=1111 stall=0", wb_rd_we, wb_rd_data, stall);
        end
        in_valid = 1; ldb = 1; stb = 1; rd_data = 16'h0300; bd_addr = 2'd3;
        mem_rdata = 16'h7777;
        tick();
        clear_inputs();
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL prio_ldb got re=%b we=%b exp re=1 we=0", mem_re, mem_we); end
        while (stall === 1'b1 && cyc < 200) begin
            if (mem_we === 1'b1) we_seen++;
            cyc++;
            tick();
        end
        mem_ready = 0;
        checks++; if (we_seen != 0 || cyc != 96) begin errors++; $display("FAIL prio_ldb_run got we_cycles=%0d beats=%0d exp 0 96", we_seen, cyc); end
        checks++; if (wb_bd_we !== 1'b1 || wb_bd_data[1535:1520] !== 16'h7777) begin
            errors++; $display("FAIL prio_ldb_wb got we=%b top=%h exp we=1 top=7777", wb_bd_we, wb_bd_data[1535:1520]);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int pulses = 0;
        clear_inputs();
        in_valid = 1; ldb = 1; rd_data = 16'h0800; bd_addr = 2'd1;
        mem_ready = 1; mem_rdata = 16'h4242;
        tick();
        clear_inputs();
        for (int i = 0; i < 40; i++) tick();
        checks++; if (mem_addr !== 16'h0828 || stall !== 1'b1) begin
            errors++; $display("FAIL rst_mid_beat40 got addr=%h stall=%b exp addr=0828 stall=1", mem_addr, stall);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++; if (stall !== 1'b0 || mem_re !== 1'b0 || wb_bd_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_abort got stall=%b re=%b bd_we=%b exp 0 0 0", stall, mem_re, wb_bd_we);
        end
        checks++; if (wb_bd_data !== '0) begin errors++; $display("FAIL rst_mid_wbdata got nonzero exp=0"); end
        for (int i = 0; i < 60; i++) begin
            if (wb_bd_we === 1'b1 || mem_re === 1'b1 || stall === 1'b1) pulses++;
            tick();
        end
        mem_ready = 0;
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d exp=0", pulses); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_wait();
        test_store_burst();
        test_load_burst();
        test_priority();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst_n in 1, reset, synchronous active-low; one clock domain.
REQ-002 SHALL have inputs from execute: in_valid 1, instruction present; rd_data 16, ALU result or memory address; bd_data 1536, bitmap result; st_data 16, store word; rd_addr 4, bd_addr 2, destination registers.
REQ-003 SHALL have op inputs, 1 bit each: ld, st, ldb (bitmap load), stb (bitmap store), wr_rd (scalar writeback), wr_bd (bitmap writeback).
REQ-004 SHALL have memory port: mem_addr out 16; mem_wdata out 16; mem_re out 1; mem_we out 1; mem_rdata in 16; mem_ready in 1, beat complete.
REQ-005 SHALL have writeback outputs: wb_rd_data 16, wb_bd_data 1536, wb_rd_addr 4, wb_bd_addr 2, wb_rd_we 1, wb_bd_we 1; and stall out 1, upstream hold.

Function
REQ-006 SHALL run an FSM with states IDLE, WORD (single scalar access) and BURST (96-beat bitmap access).
REQ-007 SHALL, in IDLE with in_valid=1, capture all inputs; op priority is ldb > stb > ld > st, and lower-priority ops asserted together are ignored.
REQ-008 SHALL, for non-memory ops, register rd_data/bd_data to wb outputs one cycle later and pulse wb_rd_we=wr_rd and wb_bd_we=wr_bd for exactly one cycle.
REQ-009 SHALL, for ld/st, enter WORD with mem_addr=captured rd_data; mem_re=1 for ld and mem_we=1 with mem_wdata=st_data for st, held until mem_ready=1.
REQ-010 SHALL, on the WORD cycle with mem_ready=1, return to IDLE; for ld, wb_rd_data=mem_rdata and wb_rd_we pulses the following cycle; st produces no writeback.
REQ-011 SHALL, for ldb/stb, enter BURST with beat counter k=0..95; mem_addr=(base+k) mod 2^16, wrapping 0xFFFF to 0x0000.
REQ-012 SHALL, for stb, drive mem_wdata=bd_data[16k+15:16k]; for ldb, write mem_rdata into buffer bits [16k+15:16k].
REQ-013 SHALL increment k only on cycles with mem_ready=1 and the request asserted; after beat 95 completes, return to IDLE.
REQ-014 SHALL, after ldb completes, present the full buffer on wb_bd_data with wb_bd_we pulsed one cycle; stb produces no writeback.
REQ-015 SHALL drive stall=1 whenever state is not IDLE; upstream holds its outputs while stall=1, and in_valid is ignored outside IDLE.
REQ-016 SHALL allow zero-wait memory: mem_ready=1 on the first request cycle completes that beat, so scalar latency is 2 cycles and bitmap latency is 97 cycles.
REQ-017 SHALL keep mem_re and mem_we mutually exclusive, both 0 in IDLE.
REQ-018 SHALL, when wb writes are not being pulsed, hold wb_rd_we=0 and wb_bd_we=0; wb data outputs hold their last value.

Reset
REQ-019 SHALL, on rst_n=0 at a clk edge, set state=IDLE, k=0, stall=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_rd_we=0, wb_bd_we=0, wb_rd_data=0, wb_bd_data=0, wb_rd_addr=0, wb_bd_addr=0.
REQ-020 SHALL, when reset occurs mid-WORD or mid-BURST, abort the access with no writeback pulse and no further memory requests; partial stores are not rolled back.

Structure
REQ-021 SHALL take BMP_BITS=1536, WORD_BITS=16, BMP_BEATS=96 and the state encoding from a shared package.
REQ-022 SHALL place the 96x16 beat buffer with indexed write and slice read in one sub-module, bmp_beat_buf.

Verification
REQ-023 Test 1: wr_rd=1, rd_data=0x1234, rd_addr=5 -> next cycle wb_rd_data=0x1234, wb_rd_addr=5, wb_rd_we=1 for 1 cycle; stall stays 0.
REQ-024 Test 2: ld, rd_data=0x0040, mem_ready low 3 cycles then mem_rdata=0xBEEF -> stall=1 for 4 cycles, mem_re=1 at addr 0x0040, then wb_rd_data=0xBEEF.
REQ-025 Test 3: stb, base=0xFFF0, bd_data beat k = k -> 96 writes; addresses 0xFFF0..0xFFFF then 0x0000..0x004F; data 0..95; no wb pulse.
REQ-026 Test 4: ldb with random mem_ready gaps, memory returns 0xA000+k -> wb_bd_data slice k = 0xA000+k; wb_bd_we pulses once.
REQ-027 Test 5: ld and st asserted together -> only the load executes (mem_we stays 0); ldb+stb together -> the bitmap load executes.
REQ-028 Test 6: rst_n=0 at beat 40 of ldb -> next cycle state IDLE, stall=0, mem_re=0, no wb_bd_we pulse.
